// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the packed {I,Q} RX sample stream: arm, trigger,
// decimate, then write a programmed number of samples into a single-port sample RAM.
module adc_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEC_W  = 8
) (
    input  logic              rx_clk,
    input  logic              rx_rst,
    input  logic [31:0]       adc_data,
    input  logic              adc_frame,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [DEC_W-1:0]  cfg_decim,
    input  logic              cfg_trig_mode,
    input  logic [11:0]       cfg_thresh,
    input  logic              arm,
    input  logic              abort,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [31:0]       buf_wdata,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W:0]   sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [DEC_W-1:0] DEC_ONE = DEC_W'(1);

    state_t            state_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [DEC_W-1:0]  decim_reg;
    logic              mode_reg;
    logic [11:0]       thresh_reg;
    logic [DEC_W-1:0]  dec_cnt_reg;
    logic              last_reg;
    logic              buf_we_reg;
    logic [ADDR_W-1:0] buf_addr_reg;
    logic [31:0]       buf_wdata_reg;
    logic              busy_reg;
    logic              triggered_reg;
    logic              done_reg;
    logic [ADDR_W:0]   cnt_reg;

    logic [11:0] sample_i;
    logic        trig_hit;
    logic        is_last;

    assign sample_i = adc_data[27:16];
    assign trig_hit = adc_frame && (!mode_reg || (sample_i >= thresh_reg));
    // Address of the write being issued equals the programmed length -> final sample.
    assign is_last  = (cnt_reg == {1'b0, len_reg});

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            decim_reg     <= '0;
            mode_reg      <= 1'b0;
            thresh_reg    <= '0;
            dec_cnt_reg   <= '0;
            last_reg      <= 1'b0;
            buf_we_reg    <= 1'b0;
            buf_addr_reg  <= '0;
            buf_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            buf_we_reg <= 1'b0;
            if (abort) begin
                state_reg     <= ST_IDLE;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b0;
                triggered_reg <= 1'b0;
                last_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            len_reg       <= cfg_len;
                            decim_reg     <= cfg_decim;
                            mode_reg      <= cfg_trig_mode;
                            thresh_reg    <= cfg_thresh;
                            cnt_reg       <= '0;
                            triggered_reg <= 1'b0;
                            done_reg      <= 1'b0;
                            busy_reg      <= 1'b1;
                            last_reg      <= 1'b0;
                            state_reg     <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        // The trigger strobe is itself the first captured sample.
                        if (trig_hit) begin
                            buf_we_reg    <= 1'b1;
                            buf_addr_reg  <= cnt_reg[ADDR_W-1:0];
                            buf_wdata_reg <= adc_data;
                            cnt_reg       <= cnt_reg + CNT_ONE;
                            last_reg      <= is_last;
                            dec_cnt_reg   <= decim_reg;
                            triggered_reg <= 1'b1;
                            state_reg     <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        // last_reg marks the cycle the final write is on the bus;
                        // strobes there are ignored and DONE follows.
                        if (last_reg) begin
                            last_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else if (adc_frame) begin
                            if (dec_cnt_reg == '0) begin
                                buf_we_reg    <= 1'b1;
                                buf_addr_reg  <= cnt_reg[ADDR_W-1:0];
                                buf_wdata_reg <= adc_data;
                                cnt_reg       <= cnt_reg + CNT_ONE;
                                last_reg      <= is_last;
                                dec_cnt_reg   <= decim_reg;
                            end else begin
                                dec_cnt_reg <= dec_cnt_reg - DEC_ONE;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign buf_we     = buf_we_reg;
    assign buf_addr   = buf_addr_reg;
    assign buf_wdata  = buf_wdata_reg;
    assign busy       = busy_reg;
    assign triggered  = triggered_reg;
    assign done       = done_reg;
    assign sample_cnt = cnt_reg;

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Capture sequencer for the packed RX sample stream (32-bit {I,Q} words qualified by a one-cycle adc_frame strobe).
- Arms on a host command and waits for a trigger, either immediate or an I-channel threshold.
- Decimates the stream, then writes a programmed number of samples into an external single-port sample RAM.
- Sits between the RX sample packer and the host-readable capture buffer, in the rx_clk domain.

Parameters:
ADDR_W, 10, sample buffer address width; max capture depth 2^ADDR_W words
DEC_W, 8, width of decimation ratio field

Ports:
rx_clk  input  1  RX sample clock; all logic rising-edge
rx_rst  input  1  synchronous, active-high reset
adc_data  input  32  packed sample {4'b0,I[11:0],4'b0,Q[11:0]}; valid only when adc_frame=1
adc_frame  input  1  one-cycle strobe per I/Q pair
cfg_len  input  ADDR_W  samples to capture minus one (0 -> 1 sample)
cfg_decim  input  DEC_W  keep 1 of every cfg_decim+1 strobes (0 -> no decimation)
cfg_trig_mode  input  1  0 = immediate, 1 = threshold on I
cfg_thresh  input  12  trigger when adc_data[27:16] >= cfg_thresh
arm  input  1  one-cycle start command
abort  input  1  one-cycle stop command
buf_we  output  1  sample RAM write enable
buf_addr  output  ADDR_W  sample RAM write address
buf_wdata  output  32  sample RAM write data
busy  output  1  high in ARMED or CAPTURE
triggered  output  1  high from trigger until next arm/abort/reset
done  output  1  high in DONE
sample_cnt  output  ADDR_W+1  samples written in current/last capture

Behaviour:
Decided: single clock rx_clk; reset rx_rst is synchronous and active-high.

Reset:
- State IDLE.
- buf_we=0, buf_addr=0, buf_wdata=0.
- busy=0, triggered=0, done=0, sample_cnt=0.
- Decimation counter and shadow config registers = 0.

States: IDLE, ARMED, CAPTURE, DONE.

IDLE/DONE + arm:
- Latch cfg_len, cfg_decim, cfg_trig_mode, cfg_thresh into shadow registers.
- Clear sample_cnt, triggered and done.
- Go to ARMED next cycle.
- Config changes after arm have no effect until the next arm.

arm while ARMED or CAPTURE:
- Ignored; no restart, shadow config unchanged.

abort in any state:
- Go to IDLE next cycle; busy=0, done=0; triggered cleared.
- Any pending write in that cycle is suppressed; sample_cnt holds its value.
- arm and abort in the same cycle: abort wins.

ARMED:
- On an adc_frame cycle where (shadow mode=0) or (I >= shadow thresh), trigger.
- The trigger sample is the first captured sample.
- Decimation counter loads shadow decim; triggered=1; go to CAPTURE.
- Strobes failing the threshold are discarded.

CAPTURE, on each adc_frame:
- If decimation counter = 0: write the sample and reload the counter with shadow decim.
- Otherwise decrement the counter; no write.

Write timing:
- buf_we is registered: high for exactly one cycle, in the cycle after the qualifying strobe.
- buf_addr = sample_cnt before increment; buf_wdata = adc_data captured at the strobe.
- sample_cnt increments in the same cycle buf_we is high.
- Latency is 1 cycle from strobe to buf_we, including the trigger sample.

Completion:
- When the write with buf_addr = shadow len is issued, go to DONE on that same edge.
- done=1 from the cycle after the last buf_we; sample_cnt = len+1.
- No further writes until the next arm.

Wrap-around / boundaries:
- cfg_len = 2^ADDR_W-1 fills the whole buffer; buf_addr never wraps; sample_cnt reaches 2^ADDR_W (hence ADDR_W+1 bits).
- cfg_len=0 writes exactly one sample.

Other:
- adc_frame outside ARMED/CAPTURE is ignored.
- Back-to-back strobes on consecutive cycles are legal and must not drop samples.
- rx_rst mid-capture returns all outputs to reset values on the next edge; no further writes.

Test Plan:
- Immediate mode, len=3, decim=0, strobes every 2 cycles with data 0x0001_0010..0x0004_0040 → 4 writes at addr 0..3 with those words; done=1 one cycle after last buf_we; sample_cnt=4.
- Threshold mode, thresh=0x800, I sequence 0x100,0x7FF,0x800,0x900 → first write is the I=0x800 word at addr 0; triggered rises with that strobe's following cycle.
- Decim=2, len=1, immediate, 6 strobes with I=1..6 → writes I=1 at addr 0 and I=4 at addr 1; strobes 2,3,5,6 not written.
- Abort after 2 of len=7 writes, with abort coincident with a qualifying strobe → no write for that strobe; IDLE; busy=0, done=0, sample_cnt=2; a later arm restarts at addr 0.
- arm pulsed again mid-CAPTURE with changed cfg_len → ignored; capture completes with the original length. arm+abort in the same cycle from IDLE → state stays IDLE.
- cfg_len=1023 with ADDR_W=10 and back-to-back strobes → 1024 consecutive writes, addr 0..1023 without wrap; sample_cnt=1024; no write after DONE.
